volume_ctrl: RTL and testbench
==============================

# volume_ctrl

Sequencer for the 4-bit volume counter. It converts held front-panel buttons and a remote step-command channel into single-cycle `up`/`down` step pulses for the counter, with auto-repeat while a button is held. Local buttons are arbitrated above remote commands, and steps are suppressed at the volume limits. It sits between the input conditioning logic and the counter, and reads the counter's `volume` back.

## Interface
- `WIDTH`, default 4, volume width; must match the counter.
- `REPEAT_DELAY`, default 8, cycles from the first pulse to the first auto-repeat pulse; minimum 2.
- `REPEAT_RATE`, default 4, cycles between auto-repeat pulses; minimum 2.

- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_up`  in  1  local up button, a synchronised level.
- `btn_down`  in  1  local down button, a synchronised level.
- `rem_valid`  in  1  remote command present.
- `rem_dir`  in  1  remote direction: 1 = up, 0 = down.
- `rem_ready`  out  1  remote command may be accepted this cycle.
- `volume`  in  WIDTH  current counter value, fed back from the counter.
- `up`  out  1  one-cycle step-up pulse to the counter.
- `down`  out  1  one-cycle step-down pulse to the counter.

## Operation
- **Reset:** `up` = 0, `down` = 0, `rem_ready` = 0, FSM = IDLE, repeat timer = 0.
- **FSM states:** IDLE, FIRST, DELAY, REPEAT.
- **Held direction:** exactly one button high. Both high, or both low, means no direction.
- **IDLE:**
  - Held direction sampled → issue a pulse, go to FIRST.
  - Otherwise, if a remote command is accepted → issue a remote pulse, stay IDLE.
- **FIRST:** lasts one cycle; loads the timer with `REPEAT_DELAY`-1, goes to DELAY.
- **DELAY:** timer decrements each cycle. At 0: issue a pulse, load `REPEAT_RATE`-1, go to REPEAT.
- **REPEAT:** timer decrements each cycle. At 0: issue a pulse and reload.
- **Release:** in FIRST, DELAY or REPEAT, no held direction → IDLE next edge; no further pulse.
- **Direction change while held** (the other button alone is now high) → behave as a fresh press from IDLE in the same edge: immediate pulse, state FIRST.
- **Remote acceptance:**
  - `rem_ready` = 1 only when FSM = IDLE, no button is high, and no pulse was issued in the previous cycle.
  - A command is accepted on an edge where `rem_valid` && `rem_ready`.
- **Saturation:**
  - An up pulse is suppressed when `volume` == 2^WIDTH-1.
  - A down pulse is suppressed when `volume` == 0.
  - A suppressed pulse still advances the FSM and timer; a remote command is still consumed.
- **Output exclusivity:** `up` and `down` are never both high. At most one pulse per cycle.

## Timing
- All outputs are registered.
- **Button press:** sampled at edge k → pulse high in cycle k..k+1.
- **First auto-repeat pulse:** `REPEAT_DELAY` cycles after the first pulse.
- **Later auto-repeat pulses:** every `REPEAT_RATE` cycles.
- **Remote:** accepted at edge k → pulse in cycle k..k+1; `rem_ready` is 0 in that cycle. Maximum remote throughput is one step per 2 cycles.
- **Saturation check:** uses `volume` sampled at the edge that issues the pulse. The counter updates one edge later; the 2-cycle minimum spacing guarantees a fresh value.
- **Reset mid-repeat:** the pulse registered in the reset cycle is cleared; no pulse occurs in the cycle after reset.

## Configuration
- **`VOLUME_CTRL_REMOTE_EN` defined:** the remote channel operates as above.
- **Not defined:**
  - `rem_ready` is tied to 0; `rem_valid` and `rem_dir` are ignored.
  - Ports remain present so the same bench compiles in both builds.
  - Only button-driven pulses occur.

## Structure
- **Package `volume_pkg`:**
  - FSM state enum typedef (IDLE, FIRST, DELAY, REPEAT).
  - Direction typedef (NONE, UP, DOWN).
  - Default `REPEAT_DELAY` and `REPEAT_RATE` constants.
- **Sub-module `rep_timer`:** a loadable down-counter with a zero flag, instantiated once. The FSM, arbitration and saturation logic are in `volume_ctrl`.

## Test plan
- **Reset:** hold `reset` = 1 for 3 cycles with `btn_up` = 1 → `up` = `down` = `rem_ready` = 0 throughout; first `up` pulse 1 cycle after `reset` falls.
- **Auto-repeat timing:** `btn_up` held 40 cycles, `volume` = 0 → `up` pulses at cycle offsets 0, 8, 12, 16, …, 36 relative to the first pulse; none after release.
- **Saturation:** `btn_down` held with the counter at `volume` = 2 → exactly 2 `down` pulses, then silence while held; `volume` stays 0.
- **Arbitration:** `rem_valid` = 1, `rem_dir` = 1 continuously while `btn_down` is pressed → `rem_ready` = 0 while the button is held; remote up pulses resume after release at most every 2 cycles.
- **Both buttons / direction change:**
  - Both buttons high → no pulses.
  - `btn_up` held, then swapped to `btn_down` in one cycle → `down` pulse on the next cycle, then the repeat delay restarts (next `down` 8 cycles later).
- **Without `VOLUME_CTRL_REMOTE_EN`:** `rem_valid` = 1 for 20 cycles → `rem_ready` = 0 and no pulses.

Source files
------------

// File: rtl/volume_pkg.sv
// Shared types and default timing constants for the volume step sequencer.
package volume_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    DELAY,
    REPEAT
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    UP,
    DOWN
  } dir_t;

  localparam int DEFAULT_REPEAT_DELAY = 8;
  localparam int DEFAULT_REPEAT_RATE  = 4;

endpackage

// File: rtl/volume_ctrl_rep_timer.sv
// Loadable down-counter with a zero flag; pacing for the auto-repeat sequence.
module rep_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // Counts down to zero and parks there until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/volume_ctrl.sv
// Button/remote to up/down step sequencer with auto-repeat and saturation.
// Remote channel is enabled by defining VOLUME_CTRL_REMOTE_EN.
module volume_ctrl
  import volume_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             rem_valid,
  input  logic             rem_dir,
  output logic             rem_ready,
  input  logic [WIDTH-1:0] volume,
  output logic             up,
  output logic             down
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]    DELAY_LOAD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]    RATE_LOAD  = TW'(REPEAT_RATE - 1);
  localparam logic [WIDTH-1:0] VOL_MAX    = '1;

  state_t        state, state_n;
  dir_t          held, held_n, dir;
  logic          step, step_up, t_load, t_zero, last_step;
  logic          remote_ok, remote_up;
  logic [TW-1:0] t_value;

  always_comb begin
    dir = NONE;
    if (btn_up && !btn_down) dir = UP;
    else if (btn_down && !btn_up) dir = DOWN;
  end

`ifdef VOLUME_CTRL_REMOTE_EN
  // Remote may step only from a quiet IDLE, which also enforces 2-cycle spacing.
  assign rem_ready = !reset && (state == IDLE) && !btn_up && !btn_down && !last_step;
  assign remote_ok = rem_valid && rem_ready;
  assign remote_up = rem_dir;
`else
  logic unused_remote;
  assign unused_remote = rem_valid ^ rem_dir ^ last_step;
  assign rem_ready     = 1'b0;
  assign remote_ok     = 1'b0;
  assign remote_up     = 1'b0;
`endif

  // Fresh presses and direction swaps restart the delay; release wins over a due repeat.
  always_comb begin
    state_n = state;
    held_n  = held;
    step    = 1'b0;
    step_up = 1'b0;
    t_load  = 1'b0;
    t_value = DELAY_LOAD;
    if (state != IDLE && dir == NONE) begin
      state_n = IDLE;
      held_n  = NONE;
    end else if (dir != NONE && (state == IDLE || dir != held)) begin
      step    = 1'b1;
      step_up = (dir == UP);
      held_n  = dir;
      t_load  = 1'b1;
      t_value = DELAY_LOAD;
      state_n = FIRST;
    end else if (state == FIRST) begin
      state_n = DELAY;
    end else if ((state == DELAY || state == REPEAT) && t_zero) begin
      step    = 1'b1;
      step_up = (held == UP);
      t_load  = 1'b1;
      t_value = RATE_LOAD;
      state_n = REPEAT;
    end else if (state == IDLE && remote_ok) begin
      step    = 1'b1;
      step_up = remote_up;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      held      <= NONE;
      up        <= 1'b0;
      down      <= 1'b0;
      last_step <= 1'b0;
    end else begin
      state     <= state_n;
      held      <= held_n;
      up        <= step && step_up && (volume != VOL_MAX);
      down      <= step && !step_up && (volume != '0);
      last_step <= step;
    end
  end

  rep_timer #(
    .W(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (t_load),
    .load_value(t_value),
    .zero      (t_zero)
  );

endmodule

// File: tb/tb_volume_ctrl.sv
// Directed self-checking bench for volume_ctrl with a behavioural volume counter.
module tb_volume_ctrl;

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, rem_valid, rem_dir;
  logic       rem_ready, up, down;
  logic [3:0] volume;
  logic       load_req, count_en;
  logic [3:0] load_val;
  int         checks = 0;
  int         failures = 0;

  volume_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .rem_valid(rem_valid),
    .rem_dir  (rem_dir),
    .rem_ready(rem_ready),
    .volume   (volume),
    .up       (up),
    .down     (down)
  );

  always #5 clk = ~clk;

  // Counter model: follows the step pulses one edge later, or takes a preset.
  always @(posedge clk) begin
    if (load_req) volume <= load_val;
    else if (count_en) begin
      if (up) volume <= volume + 4'd1;
      else if (down) volume <= volume - 4'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_volume(input logic [3:0] v, input logic en);
    load_req = 1'b1;
    load_val = v;
    count_en = en;
    tick();
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_up = 1'b1; btn_down = 1'b0; rem_valid = 1'b0; rem_dir = 1'b0;
    load_req = 1'b1; load_val = 4'd0; count_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({up, down, rem_ready} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %b expected 000", i, {up, down, rem_ready});
      end
    end
    load_req = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if ({up, down} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL first_pulse_after_reset: got %b expected 10", {up, down});
    end
    btn_up = 1'b0;
    tick();
    checks++;
    if ({up, down} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL release_after_reset: got %b expected 00", {up, down});
    end
    tick();
    tick();
  endtask

  task automatic test_auto_repeat();
    logic exp_up;
    set_volume(4'd0, 1'b0);
    btn_up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_up = (i == 0) || (i >= 8 && (i % 4) == 0);
      checks++;
      if ({up, down} !== {exp_up, 1'b0}) begin
        failures++;
        $display("[TB] FAIL auto_repeat offset %0d: got %b expected %b", i, {up, down}, {exp_up, 1'b0});
      end
    end
    btn_up = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({up, down} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL after_release cycle %0d: got %b expected 00", i, {up, down});
      end
    end
  endtask

  task automatic test_saturation();
    logic exp_down;
    int   pulses = 0;
    set_volume(4'd2, 1'b1);
    btn_down = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      exp_down = (i == 0) || (i == 8);
      if (down) pulses++;
      checks++;
      if ({up, down} !== {1'b0, exp_down}) begin
        failures++;
        $display("[TB] FAIL floor_hold offset %0d: got %b expected %b", i, {up, down}, {1'b0, exp_down});
      end
    end
    btn_down = 1'b0;
    tick();
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("[TB] FAIL down_pulse_count: got %0d expected 2", pulses);
    end
    checks++;
    if (volume !== 4'd0) begin
      failures++;
      $display("[TB] FAIL volume_floor: got %0d expected 0", volume);
    end
    tick();
    set_volume(4'd15, 1'b0);
    btn_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({up, down} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL up_ceiling offset %0d: got %b expected 00", i, {up, down});
      end
    end
    btn_up = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_direction_change();
    logic exp_down;
    set_volume(4'd8, 1'b0);
    btn_up = 1'b1;
    btn_down = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({up, down} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL both_buttons cycle %0d: got %b expected 00", i, {up, down});
      end
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    checks++;
    if ({up, down} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL swap_first_up: got %b expected 10", {up, down});
    end
    for (int i = 1; i < 5; i++) tick();
    btn_up = 1'b0;
    btn_down = 1'b1;
    tick();
    checks++;
    if ({up, down} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL swap_pulse: got %b expected 01", {up, down});
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_down = (i == 8);
      checks++;
      if ({up, down} !== {1'b0, exp_down}) begin
        failures++;
        $display("[TB] FAIL swap_delay offset %0d: got %b expected %b", i, {up, down}, {1'b0, exp_down});
      end
    end
    btn_down = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_repeat();
    set_volume(4'd3, 1'b0);
    btn_up = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({up, down, rem_ready} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_mid_repeat: got %b expected 000", {up, down, rem_ready});
    end
    btn_up = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if ({up, down} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL after_reset_quiet: got %b expected 00", {up, down});
    end
    tick();
  endtask

`ifdef VOLUME_CTRL_REMOTE_EN
  task automatic test_remote();
    logic exp_up;
    set_volume(4'd5, 1'b0);
    rem_valid = 1'b1;
    rem_dir = 1'b1;
    btn_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({rem_ready, up} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL remote_blocked cycle %0d: got %b expected 00", i, {rem_ready, up});
      end
    end
    btn_down = 1'b0;
    tick();
    checks++;
    if ({rem_ready, up, down} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL remote_ready_after_release: got %b expected 100", {rem_ready, up, down});
    end
    for (int k = 2; k < 12; k++) begin
      tick();
      exp_up = ((k % 2) == 0);
      checks++;
      if ({rem_ready, up, down} !== {!exp_up, exp_up, 1'b0}) begin
        failures++;
        $display("[TB] FAIL remote_stream step %0d: got %b expected %b", k, {rem_ready, up, down}, {!exp_up, exp_up, 1'b0});
      end
    end
    rem_valid = 1'b0;
    tick();
    tick();
  endtask
`else
  task automatic test_remote_disabled();
    rem_valid = 1'b1;
    rem_dir = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({rem_ready, up, down} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL remote_disabled cycle %0d: got %b expected 000", i, {rem_ready, up, down});
      end
    end
    rem_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_auto_repeat();
    test_saturation();
    test_direction_change();
    test_reset_mid_repeat();
`ifdef VOLUME_CTRL_REMOTE_EN
    test_remote();
`else
    test_remote_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
